// File: rtl/lane_delay_move_sequencer.sv
// Sequences LOAD/MOVE strobes for one lane's RX/TX DQS delay lines under an IO clock pause.
// All outputs are registered; tap positions are tracked here and never wrap.
module lane_delay_move_sequencer #(
   parameter int MAX_TAP   = 127,
   parameter int INIT_TAP  = 1,
   parameter int SETUP_CYC = 4,
   parameter int GAP_CYC   = 3,
   parameter int HOLD_CYC  = 4
) (
   input  logic       FAB_CLK,
   input  logic       RESET,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic       cmd_sel,
   input  logic [7:0] cmd_taps,
   output logic       busy,
   output logic       done,
   output logic       status_sat,
   output logic       status_oor,
   output logic [7:0] taps_moved,
   output logic [7:0] rx_tap,
   output logic [7:0] tx_tap,
   output logic       DELAY_LINE_SEL,
   output logic       DELAY_LINE_LOAD,
   output logic       DELAY_LINE_DIRECTION,
   output logic       DELAY_LINE_MOVE,
   output logic       HS_IO_CLK_PAUSE,
   input  logic       RX_DELAY_LINE_OUT_OF_RANGE,
   input  logic       TX_DELAY_LINE_OUT_OF_RANGE
);

   localparam logic [1:0] OP_LOAD    = 2'b00;
   localparam logic [1:0] OP_INC     = 2'b01;
   localparam logic [1:0] OP_NOP     = 2'b11;
   localparam logic [7:0] MAX_T      = 8'(MAX_TAP);
   localparam logic [7:0] INIT_T     = 8'(INIT_TAP);
   localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYC - 1);
   localparam logic [3:0] GAP_LAST   = 4'(GAP_CYC - 1);
   localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_STROBE, S_GAP, S_RELEASE, S_HOLD, S_DONE
   } state_t;

   state_t     state_q;
   logic [3:0] cnt_q;
   logic [1:0] op_q;
   logic [7:0] rem_q;
   logic       skip_q;
   logic [7:0] rx_tap_q, tx_tap_q, moved_q;
   logic       sel_q, dir_q, load_q, move_q, pause_q;
   logic       ready_q, busy_q, done_q, sat_q, oor_q;

   logic [7:0] sel_tap;
   logic [7:0] step_tap_d;
   logic       at_limit, oor_in, gap_end, go_strobe;

   always_comb begin
      sel_tap    = sel_q ? tx_tap_q : rx_tap_q;
      at_limit   = dir_q ? (sel_tap >= MAX_T) : (sel_tap == 8'd0);
      step_tap_d = dir_q ? sel_tap + 8'd1 : sel_tap - 8'd1;
      oor_in     = sel_q ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;
      gap_end    = (state_q == S_GAP) && (cnt_q == GAP_LAST);
      // Strobe slot is decided one edge early so LOAD/MOVE come straight off flops.
      go_strobe  = ((state_q == S_SETUP) && (cnt_q == SETUP_LAST)) ||
                   (gap_end && !oor_in && (op_q != OP_LOAD) && (rem_q != 8'd0));
   end

   always_ff @(posedge FAB_CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         op_q     <= OP_NOP;
         rem_q    <= 8'd0;
         skip_q   <= 1'b0;
         rx_tap_q <= INIT_T;
         tx_tap_q <= INIT_T;
         moved_q  <= 8'd0;
         sel_q    <= 1'b0;
         dir_q    <= 1'b0;
         load_q   <= 1'b0;
         move_q   <= 1'b0;
         pause_q  <= 1'b0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         sat_q    <= 1'b0;
         oor_q    <= 1'b0;
      end else begin
         load_q <= 1'b0;
         move_q <= 1'b0;
         done_q <= 1'b0;
         if (go_strobe) begin
            state_q <= S_STROBE;
            skip_q  <= 1'b0;
            if (op_q == OP_LOAD) begin
               load_q <= 1'b1;
               if (sel_q) tx_tap_q <= INIT_T;
               else       rx_tap_q <= INIT_T;
            end else if ((rem_q == 8'd0) || at_limit) begin
               skip_q <= 1'b1;
               sat_q  <= (rem_q != 8'd0);
            end else begin
               move_q  <= 1'b1;
               rem_q   <= rem_q - 8'd1;
               moved_q <= moved_q + 8'd1;
               if (sel_q) tx_tap_q <= step_tap_d;
               else       rx_tap_q <= step_tap_d;
            end
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (cmd_valid && ready_q) begin
                     op_q    <= cmd_op;
                     sel_q   <= cmd_sel;
                     dir_q   <= (cmd_op == OP_INC);
                     rem_q   <= cmd_taps;
                     sat_q   <= 1'b0;
                     oor_q   <= 1'b0;
                     moved_q <= 8'd0;
                     ready_q <= 1'b0;
                     busy_q  <= 1'b1;
                     cnt_q   <= 4'd0;
                     if (cmd_op == OP_NOP) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= S_SETUP;
                        pause_q <= 1'b1;
                     end
                  end
               end
               S_SETUP: cnt_q <= cnt_q + 4'd1;
               S_STROBE: begin
                  cnt_q <= 4'd0;
                  if (skip_q) begin
                     state_q <= S_RELEASE;
                     pause_q <= 1'b0;
                  end else begin
                     state_q <= S_GAP;
                  end
               end
               S_GAP: begin
                  // Reaching here on the last gap cycle means no further strobe is due.
                  if (gap_end) begin
                     oor_q   <= oor_in;
                     state_q <= S_RELEASE;
                     pause_q <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + 4'd1;
                  end
               end
               S_RELEASE: begin
                  state_q <= S_HOLD;
                  cnt_q   <= 4'd0;
               end
               S_HOLD: begin
                  if (cnt_q == HOLD_LAST) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 4'd1;
                  end
               end
               S_DONE: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign cmd_ready            = ready_q;
   assign busy                 = busy_q;
   assign done                 = done_q;
   assign status_sat           = sat_q;
   assign status_oor           = oor_q;
   assign taps_moved           = moved_q;
   assign rx_tap               = rx_tap_q;
   assign tx_tap               = tx_tap_q;
   assign DELAY_LINE_SEL       = sel_q;
   assign DELAY_LINE_LOAD      = load_q;
   assign DELAY_LINE_DIRECTION = dir_q;
   assign DELAY_LINE_MOVE      = move_q;
   assign HS_IO_CLK_PAUSE      = pause_q;

endmodule

// File: tb/tb_lane_delay_move_sequencer.sv
// Bench for lane_delay_move_sequencer: directed table, randomized commands against a
// command-level model, and a mid-command reset. Latency counts accept cycle through done cycle.
module tb_lane_delay_move_sequencer;

   localparam int MAXT = 127;
   localparam int INIT = 1;
   localparam int S    = 4;
   localparam int G    = 3;
   localparam int H    = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b11;
   logic       cmd_sel = 1'b0;
   logic [7:0] cmd_taps = 8'd0;
   logic       busy, done, status_sat, status_oor;
   logic [7:0] taps_moved, rx_tap, tx_tap;
   logic       dl_sel, dl_load, dl_dir, dl_move, pause;
   logic       rx_oor = 1'b0;
   logic       tx_oor = 1'b0;

   int total = 0;
   int bad   = 0;

   lane_delay_move_sequencer dut (
      .FAB_CLK(clk), .RESET(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_sel(cmd_sel), .cmd_taps(cmd_taps),
      .busy(busy), .done(done), .status_sat(status_sat), .status_oor(status_oor),
      .taps_moved(taps_moved), .rx_tap(rx_tap), .tx_tap(tx_tap),
      .DELAY_LINE_SEL(dl_sel), .DELAY_LINE_LOAD(dl_load),
      .DELAY_LINE_DIRECTION(dl_dir), .DELAY_LINE_MOVE(dl_move),
      .HS_IO_CLK_PAUSE(pause),
      .RX_DELAY_LINE_OUT_OF_RANGE(rx_oor), .TX_DELAY_LINE_OUT_OF_RANGE(tx_oor)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Command-level model: tap limits, OOR stop after strobe k, and cycle cost per phase.
   function automatic void model(input int op, input int taps, input int k, inout int tap,
                                 output int m, output int sat, output int oor,
                                 output int lat, output int nld);
      int n, skip;
      m = 0; sat = 0; oor = 0; nld = 0; skip = 0; lat = 0;
      if (op == 0) begin
         tap = INIT; nld = 1; oor = int'(k <= 1);
         lat = 1 + S + 1 + G + 1 + H + 1;
      end else if (op == 3) begin
         lat = 2;
      end else begin
         n = (op == 1) ? MAXT - tap : tap;
         if (taps < n) n = taps;
         m    = (k < n) ? k : n;
         oor  = int'(k <= n);
         sat  = int'(oor == 0 && taps > n);
         skip = int'(oor == 0 && (sat == 1 || taps == 0));
         tap  = (op == 1) ? tap + m : tap - m;
         lat  = 1 + S + m * (1 + G) + skip + 1 + H + 1;
      end
   endfunction

   task automatic run_cmd(input logic [1:0] op, input logic sel, input logic [7:0] taps,
                          input int k, input bit poke,
                          output int r_moved, output int r_sat, output int r_oor,
                          output int r_lat, output int r_nmv, output int r_nld,
                          output int r_pause, output int r_ok);
      int cyc, scnt, last, n;
      bit fin;
      r_moved = -1; r_sat = -1; r_oor = -1; r_lat = -1;
      r_nmv = 0; r_nld = 0; r_pause = 0; r_ok = 1;
      scnt = 0; last = -100; n = 0; fin = 0;
      @(negedge clk);
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      cmd_valid = 1'b1; cmd_op = op; cmd_sel = sel; cmd_taps = taps;
      @(negedge clk);
      cmd_valid = poke;
      if (poke) begin cmd_op = 2'b00; cmd_sel = ~sel; cmd_taps = 8'd9; end
      cyc = 1;
      while (!fin && cyc <= 1200) begin
         if (pause) r_pause = 1;
         if ((pause || dl_load || dl_move) && (dl_sel !== sel || dl_dir !== (op == 2'b01))) r_ok = 0;
         if (dl_load && dl_move) r_ok = 0;
         if ((dl_load || dl_move) && !pause) r_ok = 0;
         if (cmd_ready || !busy) r_ok = 0;
         if (dl_load || dl_move) begin
            if (cyc - last < G + 1) r_ok = 0;
            last = cyc; scnt++;
            if (dl_move) r_nmv++;
            if (dl_load) r_nld++;
         end
         if (sel) begin tx_oor = (scnt >= k); rx_oor = 1'($urandom_range(0, 1)); end
         else     begin rx_oor = (scnt >= k); tx_oor = 1'($urandom_range(0, 1)); end
         if (poke && cyc == 5) cmd_valid = 1'b0;
         if (done) begin
            fin = 1; r_lat = cyc + 1;
            r_moved = int'(taps_moved); r_sat = int'(status_sat); r_oor = int'(status_oor);
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      if (!fin) $display("FAIL timeout waiting for done: got no done expected done");
      cmd_valid = 1'b0; rx_oor = 1'b0; tx_oor = 1'b0;
   endtask

   typedef struct {
      logic [1:0] op; logic sel; int taps; int k; bit poke;
      int moved; int sat; int oor; int lat; int rx; int tx;
   } vec_t;

   vec_t vt[12];

   initial begin
      int mrx, mtx, tap, m, sat, oor, lat, nld;
      int a_mv, a_sat, a_oor, a_lat, a_nmv, a_nld, a_p, a_ok;
      int n;
      bit got_done;

      vt[0]  = '{2'b01, 1'b0,   3, 255, 1'b0,   3, 0, 0,  23,   4,   1};
      vt[1]  = '{2'b10, 1'b1,   5, 255, 1'b0,   1, 1, 0,  16,   4,   0};
      vt[2]  = '{2'b01, 1'b0,  10,   2, 1'b0,   2, 0, 1,  19,   6,   0};
      vt[3]  = '{2'b00, 1'b1,   0, 255, 1'b0,   0, 0, 0,  15,   6,   1};
      vt[4]  = '{2'b11, 1'b0,   0, 255, 1'b0,   0, 0, 0,   2,   6,   1};
      vt[5]  = '{2'b01, 1'b0,   0, 255, 1'b0,   0, 0, 0,  12,   6,   1};
      vt[6]  = '{2'b01, 1'b1, 200, 255, 1'b0, 126, 1, 0, 516,   6, 127};
      vt[7]  = '{2'b01, 1'b1,   1, 255, 1'b0,   0, 1, 0,  12,   6, 127};
      vt[8]  = '{2'b10, 1'b0,   6, 255, 1'b0,   6, 0, 0,  35,   0, 127};
      vt[9]  = '{2'b10, 1'b0,   1, 255, 1'b0,   0, 1, 0,  12,   0, 127};
      vt[10] = '{2'b00, 1'b0,   0,   1, 1'b0,   0, 0, 1,  15,   1, 127};
      vt[11] = '{2'b00, 1'b1,   0, 255, 1'b1,   0, 0, 0,  15,   1,   1};

      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_cmd_ready", int'(cmd_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_pause", int'(pause), 0);
      check("rst_strobes", int'({dl_load, dl_move, dl_sel, dl_dir}), 0);
      check("rst_status", int'({status_sat, status_oor}), 0);
      check("rst_taps_moved", int'(taps_moved), 0);
      check("rst_rx_tap", int'(rx_tap), INIT);
      check("rst_tx_tap", int'(tx_tap), INIT);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         run_cmd(vt[i].op, vt[i].sel, 8'(vt[i].taps), vt[i].k, vt[i].poke,
                 a_mv, a_sat, a_oor, a_lat, a_nmv, a_nld, a_p, a_ok);
         check($sformatf("vec%0d_taps_moved", i), a_mv, vt[i].moved);
         check($sformatf("vec%0d_sat", i), a_sat, vt[i].sat);
         check($sformatf("vec%0d_oor", i), a_oor, vt[i].oor);
         check($sformatf("vec%0d_latency", i), a_lat, vt[i].lat);
         check($sformatf("vec%0d_rx_tap", i), int'(rx_tap), vt[i].rx);
         check($sformatf("vec%0d_tx_tap", i), int'(tx_tap), vt[i].tx);
         check($sformatf("vec%0d_move_pulses", i), a_nmv, vt[i].moved);
         check($sformatf("vec%0d_load_pulses", i), a_nld, int'(vt[i].op == 2'b00));
         check($sformatf("vec%0d_pause_seen", i), a_p, int'(vt[i].op != 2'b11));
         check($sformatf("vec%0d_strobe_rules", i), a_ok, 1);
      end

      mrx = vt[11].rx;
      mtx = vt[11].tx;
      for (int i = 0; i < 40; i++) begin
         logic [1:0] op;
         logic       sel;
         int         taps, k;
         op   = 2'($urandom_range(0, 3));
         sel  = 1'($urandom_range(0, 1));
         taps = ($urandom_range(0, 7) == 0) ? $urandom_range(120, 255) : $urandom_range(0, 6);
         k    = ($urandom_range(0, 1) == 1) ? 255 : $urandom_range(1, 4);
         tap  = sel ? mtx : mrx;
         model(int'(op), taps, k, tap, m, sat, oor, lat, nld);
         if (op != 2'b11) begin
            if (sel) mtx = tap; else mrx = tap;
         end
         run_cmd(op, sel, 8'(taps), k, 1'b0, a_mv, a_sat, a_oor, a_lat, a_nmv, a_nld, a_p, a_ok);
         check($sformatf("rnd%0d_taps_moved", i), a_mv, m);
         check($sformatf("rnd%0d_sat", i), a_sat, sat);
         check($sformatf("rnd%0d_oor", i), a_oor, oor);
         check($sformatf("rnd%0d_latency", i), a_lat, lat);
         check($sformatf("rnd%0d_rx_tap", i), int'(rx_tap), mrx);
         check($sformatf("rnd%0d_tx_tap", i), int'(tx_tap), mtx);
         check($sformatf("rnd%0d_move_pulses", i), a_nmv, m);
         check($sformatf("rnd%0d_load_pulses", i), a_nld, nld);
         check($sformatf("rnd%0d_pause_seen", i), a_p, int'(op != 2'b11));
         check($sformatf("rnd%0d_strobe_rules", i), a_ok, 1);
      end

      // Reset in the gap after the second move of an 8-tap increment.
      @(negedge clk);
      n = 0;
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      cmd_valid = 1'b1; cmd_op = 2'b01; cmd_sel = 1'b0; cmd_taps = 8'd8;
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0; m = 0;
      while (m < 2 && n < 100) begin
         if (dl_move) m++;
         if (m < 2) begin @(negedge clk); n++; end
      end
      check("rst_mid_saw_two_moves", m, 2);
      @(negedge clk);
      check("rst_mid_pause_before", int'(pause), 1);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_pause_drop", int'(pause), 0);
      check("rst_mid_strobes_drop", int'({dl_load, dl_move}), 0);
      check("rst_mid_busy", int'(busy), 0);
      check("rst_mid_rx_tap", int'(rx_tap), INIT);
      check("rst_mid_tx_tap", int'(tx_tap), INIT);
      @(negedge clk);
      rst = 1'b0;
      got_done = 0;
      for (int c = 0; c < 30; c++) begin
         if (done || pause || dl_move) got_done = 1;
         @(negedge clk);
      end
      check("rst_mid_no_done_after", int'(got_done), 0);
      check("rst_mid_cmd_ready", int'(cmd_ready), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lane_delay_move_sequencer.md
Name: lane_delay_move_sequencer

Overview:
Command-driven sequencer for one DDR lane's LANECTRL DQS delay lines (RX and TX). It accepts load and move requests from training logic. For each request it pauses the lane's high-speed IO clock, issues spaced single-cycle LOAD/MOVE strobes, and tracks the absolute tap position of each line. Sits between the DDR PHY training FSM and the lane controller; drives the lane's DELAY_LINE_* and HS_IO_CLK_PAUSE inputs.

Parameters:
MAX_TAP, 127, highest legal tap index; moves saturate here
INIT_TAP, 1, tap position restored by a LOAD command and at reset
SETUP_CYC, 4, cycles HS_IO_CLK_PAUSE is held before the first strobe (1..15)
GAP_CYC, 3, idle cycles after each strobe before the next strobe or range check (1..15)
HOLD_CYC, 4, cycles after pause release before done (1..15)

Ports:
FAB_CLK  in  1  fabric clock; all logic on rising edge
RESET  in  1  asynchronous, active-high reset
cmd_valid  in  1  request valid
cmd_ready  out  1  high only in IDLE; accept = cmd_valid & cmd_ready
cmd_op  in  2  00 LOAD, 01 INC, 10 DEC, 11 NOP
cmd_sel  in  1  0 = RX line, 1 = TX line
cmd_taps  in  8  number of taps to move (INC/DEC only)
busy  out  1  high from accept through done
done  out  1  one-cycle completion pulse
status_sat  out  1  valid with done; move stopped at 0 or MAX_TAP
status_oor  out  1  valid with done; lane flagged out-of-range
taps_moved  out  8  valid with done; MOVE strobes actually issued
rx_tap  out  8  tracked RX tap position
tx_tap  out  8  tracked TX tap position
DELAY_LINE_SEL  out  1  registered copy of cmd_sel, stable while busy
DELAY_LINE_LOAD  out  1  one-cycle load strobe
DELAY_LINE_DIRECTION  out  1  1 = increment, 0 = decrement; stable while busy
DELAY_LINE_MOVE  out  1  one-cycle move strobe
HS_IO_CLK_PAUSE  out  1  lane clock pause request
RX_DELAY_LINE_OUT_OF_RANGE  in  1  from lane controller
TX_DELAY_LINE_OUT_OF_RANGE  in  1  from lane controller

Behaviour:
- Reset values: all outputs 0, except cmd_ready = 1, rx_tap = tx_tap = INIT_TAP. State returns to IDLE immediately on RESET, including mid-command. Strobes and pause drop asynchronously; no done is issued for the aborted command.
- States: IDLE, SETUP, STROBE, GAP, RELEASE, HOLD, DONE.
- IDLE:
  - On accept, latch op, sel and taps. Set DELAY_LINE_SEL = sel and DIRECTION = (op == INC). Clear status and taps_moved.
  - NOP goes to DONE directly (done one cycle after accept, no pause).
  - Otherwise go to SETUP with HS_IO_CLK_PAUSE = 1 from the next cycle.
- SETUP: hold for SETUP_CYC cycles, then go to STROBE.
- STROBE (one cycle):
  - LOAD: DELAY_LINE_LOAD = 1; selected tap := INIT_TAP.
  - INC/DEC with remaining count 0: go to RELEASE with no strobe.
  - INC at MAX_TAP, or DEC at 0: no strobe; status_sat = 1; go to RELEASE.
  - Otherwise: DELAY_LINE_MOVE = 1; selected tap ±1; remaining −1; taps_moved +1.
- GAP:
  - Wait GAP_CYC cycles.
  - On the last GAP cycle, sample the selected line's OUT_OF_RANGE input. If 1, set status_oor and go to RELEASE.
  - Otherwise: LOAD goes to RELEASE; INC/DEC goes to STROBE if remaining > 0, else RELEASE.
- RELEASE: HS_IO_CLK_PAUSE = 0 (one cycle), then go to HOLD.
- HOLD: HOLD_CYC cycles, then go to DONE.
- DONE: done = 1 for one cycle; status and taps_moved stay held until the next accept; go to IDLE, where cmd_ready = 1 on the following cycle.
- DELAY_LINE_SEL and DIRECTION change only in IDLE on accept. They never change while pause or any strobe is active.
- LOAD and MOVE are never high together. Back-to-back strobes are at least GAP_CYC+1 cycles apart.
- Only the selected tap register changes. Tap arithmetic is 8-bit and never wraps; saturation is detected before the strobe.
- Out-of-range inputs are ignored outside the last GAP cycle.
- Accept-to-done latency: LOAD / single move = 1 + SETUP_CYC + 1 + GAP_CYC + 1 + HOLD_CYC + 1.

Test Plan:
- Reset, then INC sel=0 taps=3 (defaults) -> pause rises 1 cycle after accept; 3 MOVE pulses 4 cycles apart with DIRECTION = 1, SEL = 0; rx_tap = 4; done with taps_moved = 3, sat = oor = 0.
- DEC sel=1 taps=5 from tx_tap = 1 -> exactly one MOVE; tx_tap = 0; status_sat = 1; taps_moved = 1; pause released.
- INC sel=0 taps=10, RX_DELAY_LINE_OUT_OF_RANGE high from the 2nd strobe onward -> 2 MOVE pulses; status_oor = 1; taps_moved = 2; TX_OUT_OF_RANGE toggling has no effect.
- LOAD sel=1 after moves -> single LOAD pulse with pause high; tx_tap = 1; latency 1+4+1+3+1+4+1 = 15 cycles; NOP -> done 1 cycle after accept, no pause.
- RESET asserted during GAP of an INC taps=8 -> pause and strobes drop immediately; no done; rx_tap = tx_tap = 1; cmd_ready = 1 after release; cmd_valid held during busy is not accepted.
